prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 124 ++++++++++++
 tb/tb_prog_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Host-driven program loader: streams machine-code words into instruction memory,
// pulses the processor start, then times the run until cpu_done or saturation.
module prog_loader #(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_req,
    input  logic [D:0]   len,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         im_wr_en,
    output logic [D-1:0] im_addr,
    output logic [W-1:0] im_wr_data,
    output logic         cpu_start,
    input  logic         cpu_done,
    output logic         busy,
    output logic         run_done,
    output logic [15:0]  cycles,
    output logic         err
);

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE} state_t;

    localparam logic [D:0] MAX_LEN = {1'b1, {D{1'b0}}};

    state_t      state, state_nx;
    logic [D:0]  len_q, len_nx;
    logic [D:0]  wr_cnt, wr_cnt_nx;
    logic [15:0] cycles_q, cycles_nx;
    logic        err_q, err_nx;
    logic        done_q, done_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            len_q    <= '0;
            wr_cnt   <= '0;
            cycles_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            len_q    <= len_nx;
            wr_cnt   <= wr_cnt_nx;
            cycles_q <= cycles_nx;
            err_q    <= err_nx;
            done_q   <= done_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        len_nx     = len_q;
        wr_cnt_nx  = wr_cnt;
        cycles_nx  = cycles_q;
        err_nx     = err_q;
        done_nx    = done_q;
        in_ready   = 1'b0;
        im_wr_en   = 1'b0;
        im_addr    = wr_cnt[D-1:0];
        im_wr_data = in_data;
        cpu_start  = 1'b0;
        busy       = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (load_req) begin
                    done_nx   = 1'b0;
                    err_nx    = 1'b0;
                    cycles_nx = '0;
                    wr_cnt_nx = '0;
                    len_nx    = (len > MAX_LEN) ? MAX_LEN : len;
                    state_nx  = (len != '0) ? LOAD : START;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                im_wr_en = in_valid;
                if (in_valid) begin
                    wr_cnt_nx = wr_cnt + (D+1)'(1);
                    if (wr_cnt + (D+1)'(1) == len_q)
                        state_nx = START;
                end
            end
            START: begin
                // cpu_done deliberately not looked at here: it may be left over from the last run
                busy      = 1'b1;
                cpu_start = 1'b1;
                state_nx  = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cpu_done) begin
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end else if (cycles_q == 16'hFFFF) begin
                    err_nx   = 1'b1;
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end else begin
                    cycles_nx = cycles_q + 16'd1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // strobes drop with reset itself, not with the next clock
        if (reset) begin
            in_ready  = 1'b0;
            im_wr_en  = 1'b0;
            cpu_start = 1'b0;
            busy      = 1'b0;
        end
    end

    assign cycles   = cycles_q;
    assign err      = err_q;
    assign run_done = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued as words are
// driven and popped by a negedge monitor; session results are checked per task.
module tb_prog_loader;
    localparam int D = 12;
    localparam int W = 9;

    logic         clk = 0, reset = 0, load_req = 0, in_valid = 0, cpu_done = 0;
    logic [D:0]   len = '0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, im_wr_en, cpu_start, busy, run_done, err;
    logic [D-1:0] im_addr;
    logic [W-1:0] im_wr_data;
    logic [15:0]  cycles;

    int n_cmp = 0, n_bad = 0;

    typedef struct packed {
        logic [D-1:0] addr;
        logic [W-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    prog_loader #(.D(D), .W(W)) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .im_wr_en(im_wr_en), .im_addr(im_addr), .im_wr_data(im_wr_data),
        .cpu_start(cpu_start), .cpu_done(cpu_done), .busy(busy),
        .run_done(run_done), .cycles(cycles), .err(err)
    );

    always #5 clk = ~clk;

    // write monitor: every strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (im_wr_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexpected: got addr %0h data %0h, required no write", im_addr, im_wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({im_addr, im_wr_data} !== {e.addr, e.data}) begin
                    n_bad++;
                    $display("FAIL wr_data: got addr %0h data %0h, required addr %0h data %0h",
                             im_addr, im_wr_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_session(input int l);
        load_req = 1; len = l[D:0];
        tick();
        load_req = 0; len = '0;
    endtask

    task automatic send_word(input int a, input logic [W-1:0] d);
        in_valid = 1; in_data = d;
        exp_q.push_back({a[D-1:0], d});
        #2;
        n_cmp++;
        if ({in_ready, im_wr_en, im_addr} !== {1'b1, 1'b1, a[D-1:0]}) begin
            n_bad++;
            $display("FAIL wr_strobe: got rdy/en/addr %b/%b/%0h, required 1/1/%0h", in_ready, im_wr_en, im_addr, a);
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    // called one step after the edge that entered START
    task automatic finish_run(input int n, input string tag);
        @(negedge clk);
        n_cmp++;
        if (cpu_start !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_start: got cpu_start %b, required 1", tag, cpu_start);
        end
        tick();
        cpu_done = 0;
        n_cmp++;
        if ({cpu_start, busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL %s_run: got start/busy %b/%b, required 0/1", tag, cpu_start, busy);
        end
        repeat (n) tick();
        cpu_done = 1;
        tick();
        cpu_done = 0;
        @(negedge clk);
        n_cmp++;
        if ({cycles, run_done, err, busy} !== {n[15:0], 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL %s_done: got cycles %0d done %b err %b busy %b, required %0d 1 0 0",
                     tag, cycles, run_done, err, busy, n);
        end
        tick();
    endtask

    task automatic test_reset();
        #1 reset = 1;
        #2;
        n_cmp++;
        if ({in_ready, im_wr_en, cpu_start, busy, run_done, err, cycles} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got rdy %b en %b st %b busy %b done %b err %b cyc %0d, required all 0",
                     in_ready, im_wr_en, cpu_start, busy, run_done, err, cycles);
        end
        @(negedge clk); reset = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [3];
        words[0] = 9'h1A5; words[1] = 9'h003; words[2] = 9'h1FF;
        start_session(3);
        for (int i = 0; i < 3; i++) send_word(i, words[i]);
        finish_run(5, "b2b");
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_pending: got %0d writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_gaps();
        start_session(3);
        for (int i = 0; i < 3; i++) begin
            send_word(i, 9'(9'h040 + i * 7));
            if (i < 2) begin
                for (int g = 0; g < 2; g++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (in_ready !== 1'b1) begin
                        n_bad++;
                        $display("FAIL gap_ready: got in_ready %b, required 1", in_ready);
                    end
                    tick();
                end
            end
        end
        finish_run(400, "gap400");
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL gap_pending: got %0d writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int k;
        start_session(0);
        tick();
        k = 0;
        while (k < 70000 && run_done !== 1'b1) begin
            tick();
            k++;
        end
        @(negedge clk);
        n_cmp++;
        if ({run_done, err, cycles, busy} !== {1'b1, 1'b1, 16'hFFFF, 1'b0}) begin
            n_bad++;
            $display("FAIL timeout: got done %b err %b cycles %0h busy %b, required 1 1 ffff 0",
                     run_done, err, cycles, busy);
        end
        tick();
        cpu_done = 1;  // stale done while START is entered
        start_session(0);
        n_cmp++;
        if ({run_done, err, cycles} !== '0) begin
            n_bad++;
            $display("FAIL relaunch_clear: got done %b err %b cycles %0h, required 0 0 0", run_done, err, cycles);
        end
        finish_run(3, "stale");
    endtask

    task automatic test_len0_ignore();
        start_session(0);
        @(negedge clk);
        n_cmp++;
        if ({cpu_start, im_wr_en, in_ready} !== 3'b100) begin
            n_bad++;
            $display("FAIL len0_start: got st/en/rdy %b/%b/%b, required 1/0/0", cpu_start, im_wr_en, in_ready);
        end
        tick();
        repeat (3) tick();
        load_req = 1; len = 13'd7;
        tick();
        load_req = 0; len = '0;
        n_cmp++;
        if ({busy, in_ready, run_done} !== 3'b100) begin
            n_bad++;
            $display("FAIL run_ignore_req: got busy/rdy/done %b/%b/%b, required 1/0/0", busy, in_ready, run_done);
        end
        repeat (2) tick();
        cpu_done = 1;
        tick();
        cpu_done = 0;
        @(negedge clk);
        n_cmp++;
        if ({cycles, run_done, err} !== {16'd6, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL len0_done: got cycles %0d done %b err %b, required 6 1 0", cycles, run_done, err);
        end
        tick();
    endtask

    task automatic test_reset_mid_load();
        start_session(5);
        send_word(0, 9'h111);
        send_word(1, 9'h122);
        in_valid = 1; in_data = 9'h155;
        #2 reset = 1;
        #1;
        n_cmp++;
        if ({in_ready, im_wr_en, cpu_start, busy, run_done, cycles} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got rdy %b en %b st %b busy %b done %b cyc %0d, required all 0",
                     in_ready, im_wr_en, cpu_start, busy, run_done, cycles);
        end
        in_valid = 0;
        @(posedge clk); #1 reset = 0;
        tick();
        start_session(1);
        send_word(0, 9'h0AB);
        finish_run(1, "after_rst");
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rst_pending: got %0d writes missing, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_len0_ignore();
        test_reset_mid_load();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
